// File: rtl/dpe_ingress_arbiter.sv
// dpe_ingress_arbiter: packet-level round-robin merge of N_SRC AXI-Stream ingress FIFOs onto one stream.
// Ports:
//   i_clk, i_rst (asynchronous, active-low)
//   i_cfg_src_en            per-source enable, only consulted while arbitrating in IDLE
//   i_s_*/o_s_tready        per-source AXI-Stream slaves, source i at slice i
//   o_m_*/i_m_tready        merged AXI-Stream master, o_m_tuser_src stamps the granted source
//   o_grant_vld/o_grant_src packet grant active / current or last granted source
// Build option: define DPE_ARB_CPU_PRIO_EN to let source 0 win every arbitration it requests.
module dpe_ingress_arbiter #(
  parameter int N_SRC  = 5,
  parameter int DATA_W = 128,
  parameter int KEEP_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_SRC-1:0]         i_cfg_src_en,
  input  logic [N_SRC-1:0]         i_s_tvalid,
  output logic [N_SRC-1:0]         o_s_tready,
  input  logic [N_SRC*DATA_W-1:0]  i_s_tdata,
  input  logic [N_SRC*KEEP_W-1:0]  i_s_tkeep,
  input  logic [N_SRC-1:0]         i_s_tlast,
  input  logic [N_SRC-1:0]         i_s_tuser_bypass_all,
  input  logic [N_SRC-1:0]         i_s_tuser_bypass_stg,
  input  logic [N_SRC*ADDR_W-1:0]  i_s_tuser_dst,
  output logic                     o_m_tvalid,
  input  logic                     i_m_tready,
  output logic [DATA_W-1:0]        o_m_tdata,
  output logic [KEEP_W-1:0]        o_m_tkeep,
  output logic                     o_m_tlast,
  output logic                     o_m_tuser_bypass_all,
  output logic                     o_m_tuser_bypass_stg,
  output logic [ADDR_W-1:0]        o_m_tuser_src,
  output logic [ADDR_W-1:0]        o_m_tuser_dst,
  output logic                     o_grant_vld,
  output logic [ADDR_W-1:0]        o_grant_src
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_grant_src, w_pick, w_idx;
  logic [N_SRC-1:0] w_req;
  assign w_req = i_s_tvalid & i_cfg_src_en;
  // Scanning from farthest to nearest lets the nearest requester after the pointer win.
  always_comb begin
    w_pick = r_grant_src;
    w_idx = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      w_idx = ADDR_W'((int'(r_grant_src) + k) % N_SRC);
      if (w_req[w_idx]) w_pick = w_idx;
    end
`ifdef DPE_ARB_CPU_PRIO_EN
    if (w_req[0]) w_pick = '0;
`endif
  end
  always_comb begin
    o_s_tready = '0;
    o_m_tvalid = 1'b0;
    o_m_tdata = '0;
    o_m_tkeep = '0;
    o_m_tlast = 1'b0;
    o_m_tuser_bypass_all = 1'b0;
    o_m_tuser_bypass_stg = 1'b0;
    o_m_tuser_dst = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_state == PKT && r_grant_src == ADDR_W'(i)) begin
        o_s_tready[i] = i_m_tready;
        o_m_tvalid = i_s_tvalid[i];
        o_m_tdata = i_s_tdata[i*DATA_W +: DATA_W];
        o_m_tkeep = i_s_tkeep[i*KEEP_W +: KEEP_W];
        o_m_tlast = i_s_tlast[i];
        o_m_tuser_bypass_all = i_s_tuser_bypass_all[i];
        o_m_tuser_bypass_stg = i_s_tuser_bypass_stg[i];
        o_m_tuser_dst = i_s_tuser_dst[i*ADDR_W +: ADDR_W];
      end
    end
    o_m_tuser_src = r_state == PKT ? r_grant_src : '0;
    w_state_nxt = r_state == IDLE ? (|w_req ? PKT : IDLE)
                                  : (o_m_tvalid && i_m_tready && o_m_tlast ? IDLE : PKT);
  end
  assign o_grant_vld = r_state == PKT;
  assign o_grant_src = r_grant_src;
  // Pointer resets to the last source so source 0 is first in the scan.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_grant_src <= ADDR_W'(N_SRC - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && |w_req) r_grant_src <= w_pick;
    end
  end
endmodule

// File: tb/tb_dpe_ingress_arbiter.sv
// tb_dpe_ingress_arbiter: directed scoreboard bench for dpe_ingress_arbiter
module tb_dpe_ingress_arbiter;
  localparam int N = 5, DW = 128, KW = 16, AW = 3;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          ba;
    logic          bs;
    logic [AW-1:0] dst;
  } beat_t;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] cfg_en, s_tvalid, s_tready, s_tlast, s_ba, s_bs;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*AW-1:0] s_dst;
  logic m_tvalid, m_tready, m_tlast, m_ba, m_bs, grant_vld;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [AW-1:0] m_src, m_dst, grant_src;
  logic [153:0] out_vec, prev_vec;
  assign out_vec = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_ba, m_bs, m_src, m_dst};
  always #5 clk = ~clk;
  dpe_ingress_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_src_en(cfg_en),
    .i_s_tvalid(s_tvalid), .o_s_tready(s_tready), .i_s_tdata(s_tdata), .i_s_tkeep(s_tkeep),
    .i_s_tlast(s_tlast), .i_s_tuser_bypass_all(s_ba), .i_s_tuser_bypass_stg(s_bs),
    .i_s_tuser_dst(s_dst), .o_m_tvalid(m_tvalid), .i_m_tready(m_tready), .o_m_tdata(m_tdata),
    .o_m_tkeep(m_tkeep), .o_m_tlast(m_tlast), .o_m_tuser_bypass_all(m_ba),
    .o_m_tuser_bypass_stg(m_bs), .o_m_tuser_src(m_src), .o_m_tuser_dst(m_dst),
    .o_grant_vld(grant_vld), .o_grant_src(grant_src)
  );
  beat_t src_q[N][$];
  beat_t exp_q[N][$];
  int tests = 0, fails = 0, ord_n = 0, beats = 0, pid = 0, ncyc;
  logic [31:0] ord = '0;
  logic [N-1:0] rdy_seen = '0;
  bit in_pkt = 0, stall_prev = 0, toggle_rdy = 0;
`ifdef DPE_ARB_CPU_PRIO_EN
  localparam logic [31:0] T6_ORD = 32'o000222;
`else
  localparam logic [31:0] T6_ORD = 32'o020202;
`endif
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b = src_q[i].size() != 0 ? src_q[i][0] : '0;
      s_tvalid[i] = src_q[i].size() != 0;
      s_tdata[i*DW +: DW] = b.data;
      s_tkeep[i*KW +: KW] = b.keep;
      s_tlast[i] = b.last;
      s_ba[i] = b.ba;
      s_bs[i] = b.bs;
      s_dst[i*AW +: AW] = b.dst;
    end
  endtask
  task automatic add_pkt(input int s, input int n);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data = {$urandom, $urandom, $urandom, 8'(s), 8'(pid), 16'(j)};
      b.keep = KW'($urandom);
      b.last = j == n - 1;
      b.ba = 1'($urandom);
      b.bs = 1'($urandom);
      b.dst = AW'($urandom);
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
    pid++;
    drive();
  endtask
  task automatic cycle();
    bit mhs;
    beat_t mb, e;
    logic [AW-1:0] msrc;
    logic [N-1:0] shs;
    @(negedge clk);
    chk("tready_onehot0", $onehot0(s_tready), 1'b1);
    rdy_seen |= s_tready;
    if (stall_prev) chk("stall_hold", out_vec, prev_vec);
    prev_vec = out_vec;
    stall_prev = m_tvalid & ~m_tready;
    mhs = m_tvalid & m_tready;
    mb = {m_tdata, m_tkeep, m_tlast, m_ba, m_bs, m_dst};
    msrc = m_src;
    shs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    if (mhs) begin
      beats++;
      if (!in_pkt) begin
        ord = {ord[28:0], msrc};
        ord_n++;
      end
      in_pkt = !mb.last;
      chk("beat_expected", (msrc < N) && exp_q[msrc].size() != 0, 1'b1);
      if (msrc < N && exp_q[msrc].size() != 0) begin
        e = exp_q[msrc].pop_front();
        chk("beat", mb, e);
      end
    end
    for (int i = 0; i < N; i++) if (shs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    if (toggle_rdy) m_tready = ~m_tready;
    drive();
  endtask
  task automatic run_drain(input string tag, input int bound, output int n);
    n = 0;
    while (!all_empty() && n < bound) begin
      cycle();
      n++;
    end
    chk(tag, all_empty(), 1'b1);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_grant_src", grant_src, 3'd4);
    chk("rst_grant_vld", grant_vld, 1'b0);
    chk("rst_s_tready", s_tready, 5'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_outputs", out_vec, 154'b0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ord = '0;
    ord_n = 0;
    beats = 0;
    in_pkt = 0;
    stall_prev = 0;
    rdy_seen = '0;
  endtask
  initial begin
    rst = 1'b1;
    m_tready = 1'b1;
    cfg_en = 5'b11111;
    drive();
    #3;
    do_reset();
    add_pkt(3, 4);
    run_drain("t1_drain", 20, ncyc);
    chk("t1_cycles", ncyc, 5);
    chk("t1_beats", beats, 4);
    chk("t1_order", ord, 32'o3);
    chk("t1_grant_src", grant_src, 3'd3);
    chk("t1_idle", grant_vld, 1'b0);
    do_reset();
    for (int s = 0; s < N; s++) add_pkt(s, 2);
    run_drain("t2_drain", 40, ncyc);
    chk("t2_cycles", ncyc, 15);
    chk("t2_order", ord, 32'o01234);
    chk("t2_count", ord_n, 5);
    do_reset();
    add_pkt(1, 3);
    toggle_rdy = 1;
    run_drain("t3_drain", 30, ncyc);
    toggle_rdy = 0;
    m_tready = 1'b1;
    chk("t3_beats", beats, 3);
    chk("t3_rdy_seen", rdy_seen, 5'b00010);
    do_reset();
    cfg_en = 5'b11101;
    add_pkt(0, 2);
    add_pkt(1, 2);
    add_pkt(2, 3);
    add_pkt(2, 2);
    add_pkt(3, 2);
    add_pkt(4, 2);
    repeat (5) cycle();
    chk("t4_mid_grant", {grant_vld, grant_src}, {1'b1, 3'd2});
    cfg_en = 5'b11001;
    repeat (20) cycle();
    chk("t4_order", ord, 32'o0234);
    chk("t4_count", ord_n, 4);
    chk("t4_src1_left", exp_q[1].size(), 2);
    chk("t4_src2_left", exp_q[2].size(), 2);
    chk("t4_src1_never_ready", rdy_seen[1], 1'b0);
    cfg_en = 5'b11111;
    do_reset();
    add_pkt(3, 5);
    repeat (2) cycle();
    chk("t5_in_pkt", {grant_vld, m_tvalid}, 2'b11);
    do_reset();
    add_pkt(2, 1);
    add_pkt(0, 1);
    run_drain("t5_drain", 20, ncyc);
    chk("t5_order", ord, 32'o02);
    chk("t5_count", ord_n, 2);
    do_reset();
    for (int j = 0; j < 3; j++) begin
      add_pkt(0, 1);
      add_pkt(2, 1);
    end
    run_drain("t6_drain", 40, ncyc);
    chk("t6_cycles", ncyc, 12);
    chk("t6_order", ord, T6_ORD);
    chk("t6_count", ord_n, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
